// File: rtl/loom_scan_pkg.sv
// -----------------------------------------------------------------------------
// loom_scan_pkg
// Shared definitions for the scan-chain controller and the host-side command
// driver: command codes and the controller state encoding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package loom_scan_pkg;

  // Command codes carried on cmd_i. Codes 3..7 are reserved and ignored.
  localparam logic [2:0] ScanCmdNop     = 3'd0;
  localparam logic [2:0] ScanCmdCapture = 3'd1;
  localparam logic [2:0] ScanCmdRestore = 3'd2;

  typedef enum logic [1:0] {
    ScanIdle   = 2'd0,
    ScanFreeze = 2'd1,
    ScanShift  = 2'd2,
    ScanDone   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/loom_scan_ctrl.sv
// -----------------------------------------------------------------------------
// loom_scan_ctrl
// Serial scan-chain controller. On a Capture or Restore command it freezes the
// user design, waits FreezeCycles settle cycles, then shifts the single-bit
// chain for N cycles. Capture loops the chain tail back to its head while
// recording the first W bits (non-destructive); Restore drives the data word
// into the chain head, padding with zeros beyond W bits.
//
// Ports
//   clk_i          design clock
//   rst_ni         asynchronous active-low reset
//   cmd_valid_i    single-cycle command strobe
//   cmd_i          command code (Nop / Capture / Restore, others reserved)
//   shift_count_i  number of shift cycles N
//   data_i         restore data word
//   data_o         data register (captured or echoed word)
//   busy_o         command in progress (Freeze and Shift states)
//   done_o         single-cycle completion pulse
//   freeze_o       user design clock-enable low
//   scan_enable_o  chain shift enable
//   scan_in_o      serial data into the chain head
//   scan_out_i     serial data from the chain tail
//   state_o        current FSM state, for observation only
//
// Handshake: a command is taken when cmd_valid_i is high in a cycle where the
// FSM is Idle and cmd_i is Capture or Restore. Any strobe seen outside Idle is
// dropped, there is no queue; the host waits for done_o before issuing again.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module loom_scan_ctrl
  import loom_scan_pkg::*;
#(
  parameter int ScanDataWidth = 64,
  parameter int FreezeCycles  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  input  logic [2:0]               cmd_i,
  input  logic [15:0]              shift_count_i,
  input  logic [ScanDataWidth-1:0] data_i,
  output logic [ScanDataWidth-1:0] data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     freeze_o,
  output logic                     scan_enable_o,
  output logic                     scan_in_o,
  input  logic                     scan_out_i,
  output scan_state_e              state_o
);

  // Bit index into the data word; the shift counter is 16 bits wide, so words
  // wider than 65536 bits are not reachable anyway.
  localparam int IdxW = (ScanDataWidth > 1) ? $clog2(ScanDataWidth) : 1;
  localparam logic [3:0] SettleLast = 4'(FreezeCycles - 1);

  scan_state_e state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] n_q;
  logic [2:0]  op_q;
  logic [ScanDataWidth-1:0] data_q;

  logic busy_q, done_q, freeze_q, scan_en_q, scan_bit_q;
  logic accept;
  logic cur_in_range, next_in_range;
  logic [IdxW-1:0] cur_idx, next_idx;
  logic op_is_capture, op_is_restore;

  assign op_is_capture = (op_q == ScanCmdCapture);
  assign op_is_restore = (op_q == ScanCmdRestore);

  assign cur_idx       = shift_q[IdxW-1:0];
  assign next_idx      = shift_d[IdxW-1:0];
  assign cur_in_range  = (int'(shift_q) < ScanDataWidth);
  assign next_in_range = (int'(shift_d) < ScanDataWidth);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    shift_d  = shift_q;
    accept   = 1'b0;
    unique case (state_q)
      ScanIdle: begin
        if (cmd_valid_i && (cmd_i == ScanCmdCapture || cmd_i == ScanCmdRestore)) begin
          accept   = 1'b1;
          state_d  = ScanFreeze;
          settle_d = '0;
          shift_d  = '0;
        end
      end
      ScanFreeze: begin
        if (settle_q == SettleLast) begin
          state_d = (n_q == 16'd0) ? ScanDone : ScanShift;
          shift_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ScanShift: begin
        // Compare against N-1 so N=65535 finishes without the counter wrapping.
        if (shift_q == n_q - 16'd1) begin
          state_d = ScanDone;
        end else begin
          shift_d = shift_q + 16'd1;
        end
      end
      ScanDone: begin
        state_d = ScanIdle;
      end
      default: begin
        state_d = ScanIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, data register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ScanIdle;
      settle_q   <= '0;
      shift_q    <= '0;
      n_q        <= '0;
      op_q       <= ScanCmdNop;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      freeze_q   <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_bit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      shift_q  <= shift_d;

      if (accept) begin
        op_q   <= cmd_i;
        n_q    <= shift_count_i;
        data_q <= (cmd_i == ScanCmdCapture) ? '0 : data_i;
      end else if (state_q == ScanShift && op_is_capture && cur_in_range) begin
        data_q[cur_idx] <= scan_out_i;
      end

      busy_q    <= (state_d == ScanFreeze) || (state_d == ScanShift);
      freeze_q  <= (state_d != ScanIdle);
      scan_en_q <= (state_d == ScanShift);
      done_q    <= (state_d == ScanDone);

      // Restore bit for the upcoming shift cycle. The data register is loaded
      // at accept, at least one Freeze cycle before the first shift.
      scan_bit_q <= (state_d == ScanShift) && op_is_restore && next_in_range
                    ? data_q[next_idx] : 1'b0;
    end
  end

  assign data_o        = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign freeze_o      = freeze_q;
  assign scan_enable_o = scan_en_q;
  assign state_o       = state_q;

  // Capture rotates the chain: tail feeds head with no register in between.
  assign scan_in_o = (state_q == ScanShift && op_is_capture) ? scan_out_i : scan_bit_q;

endmodule

// File: tb/tb_loom_scan_ctrl.sv
`timescale 1ns/1ps
module tb_loom_scan_ctrl;
  import loom_scan_pkg::*;

  localparam int W = 64;
  localparam int F = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_code = ScanCmdNop;
  logic [15:0]  shift_count = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         busy, done, freeze, scan_en, scan_in, scan_out;
  scan_state_e  state;

  loom_scan_ctrl #(.ScanDataWidth(W), .FreezeCycles(F)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_i(cmd_code),
    .shift_count_i(shift_count), .data_i(data_in), .data_o(data_out),
    .busy_o(busy), .done_o(done), .freeze_o(freeze), .scan_enable_o(scan_en),
    .scan_in_o(scan_in), .scan_out_i(scan_out), .state_o(state)
  );

  // ---------------------------------------------------------------------------
  // Scan chain model: bit 0 is the tail, bit chain_len-1 is the head.
  // ---------------------------------------------------------------------------
  logic [127:0] chain = '0;
  logic [127:0] load_val = '0;
  logic         load_req = 1'b0;
  int           chain_len = 8;
  int           en_cnt = 0;
  int           done_cnt = 0;
  logic         sin_log [0:1023];

  assign scan_out = chain[0];

  always @(posedge clk) begin
    logic [127:0] nx;
    if (load_req) begin
      chain <= load_val;
    end else if (scan_en) begin
      nx = chain >> 1;
      nx[chain_len-1] = scan_in;
      chain <= nx;
      if (en_cnt < 1024) sin_log[en_cnt] <= scan_in;
      en_cnt <= en_cnt + 1;
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic load_chain(input logic [127:0] v, input int len);
    @(negedge clk);
    chain_len = len;
    load_val  = v;
    load_req  = 1'b1;
    @(negedge clk);
    load_req  = 1'b0;
  endtask

  // Issues one command and follows it to done_o. Optionally injects a second
  // strobe at cycle inject_cyc, and/or during the Done cycle.
  task automatic run_cmd(input logic [2:0] cmd, input logic [15:0] n,
                         input logic [W-1:0] d, input int inject_cyc,
                         input bit inject_done, output int lat);
    int limit;
    limit = int'(n) + F + 20;
    lat = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = cmd; shift_count = n; data_in = d;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (cyc == inject_cyc) begin
        cmd_valid = 1'b1; cmd_code = ScanCmdRestore; shift_count = 16'd3; data_in = '1;
      end
      if (cyc == 1) begin
        n_vec++;
        if ({busy, freeze} !== 2'b11) begin
          n_err++; $display("FAIL first_cycle busy/freeze: got %b expected 11", {busy, freeze});
        end
      end
      if (done) begin
        lat = cyc;
        n_vec++;
        if ({busy, freeze} !== 2'b01) begin
          n_err++; $display("FAIL done_cycle busy/freeze: got %b expected 01", {busy, freeze});
        end
        if (inject_done) begin
          cmd_valid = 1'b1; cmd_code = ScanCmdCapture; shift_count = 16'd4;
        end
        break;
      end
    end
    if (lat < 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", limit);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_vec++;
    if ({busy, freeze, done} !== 3'b000) begin
      n_err++; $display("FAIL after_done busy/freeze/done: got %b expected 000", {busy, freeze, done});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, freeze, scan_en, scan_in} !== 5'b00000) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 00000", {busy, done, freeze, scan_en, scan_in});
    end
    n_vec++;
    if (data_out !== 64'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", data_out);
    end
    n_vec++;
    if (state !== ScanIdle) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", state, ScanIdle);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_capture();
    int lat, e0;
    load_chain(128'hA5, 8);
    e0 = en_cnt;
    run_cmd(ScanCmdCapture, 16'd8, '0, 0, 1'b0, lat);
    n_vec++;
    if (lat !== 10) begin n_err++; $display("FAIL capture_latency: got %0d expected 10", lat); end
    n_vec++;
    if (data_out !== 64'h00000000000000A5) begin
      n_err++; $display("FAIL capture_data: got %h expected 00000000000000a5", data_out);
    end
    n_vec++;
    if (chain[7:0] !== 8'hA5) begin n_err++; $display("FAIL capture_chain: got %h expected a5", chain[7:0]); end
    n_vec++;
    if (en_cnt - e0 !== 8) begin n_err++; $display("FAIL capture_enables: got %0d expected 8", en_cnt - e0); end
  endtask

  task automatic test_restore_capture();
    int lat;
    run_cmd(ScanCmdRestore, 16'd8, 64'h3C, 0, 1'b0, lat);
    n_vec++;
    if (lat !== 10) begin n_err++; $display("FAIL restore_latency: got %0d expected 10", lat); end
    n_vec++;
    if (chain[7:0] !== 8'h3C) begin n_err++; $display("FAIL restore_chain: got %h expected 3c", chain[7:0]); end
    n_vec++;
    if (data_out !== 64'h3C) begin n_err++; $display("FAIL restore_echo: got %h expected 3c", data_out); end
    run_cmd(ScanCmdCapture, 16'd8, '1, 0, 1'b0, lat);
    n_vec++;
    if (data_out !== 64'h3C) begin n_err++; $display("FAIL recapture_data: got %h expected 3c", data_out); end
    n_vec++;
    if (chain[7:0] !== 8'h3C) begin n_err++; $display("FAIL recapture_chain: got %h expected 3c", chain[7:0]); end
  endtask

  task automatic test_zero_count();
    int lat, e0;
    e0 = en_cnt;
    run_cmd(ScanCmdCapture, 16'd0, '0, 0, 1'b0, lat);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL zero_latency: got %0d expected 2", lat); end
    n_vec++;
    if (en_cnt - e0 !== 0) begin n_err++; $display("FAIL zero_enables: got %0d expected 0", en_cnt - e0); end
    n_vec++;
    if (data_out !== 64'h0) begin n_err++; $display("FAIL zero_data: got %h expected 0", data_out); end
  endtask

  task automatic test_long_chain();
    int lat, e0;
    logic [69:0] got;
    load_chain({32{4'h5}}, 70);
    e0 = en_cnt;
    run_cmd(ScanCmdCapture, 16'd70, '0, 0, 1'b0, lat);
    n_vec++;
    if (lat !== 72) begin n_err++; $display("FAIL long_capture_latency: got %0d expected 72", lat); end
    n_vec++;
    if (data_out !== 64'h5555_5555_5555_5555) begin
      n_err++; $display("FAIL long_capture_data: got %h expected 5555555555555555", data_out);
    end
    n_vec++;
    if (en_cnt - e0 !== 70) begin n_err++; $display("FAIL long_capture_enables: got %0d expected 70", en_cnt - e0); end
    n_vec++;
    if (chain[69:0] !== 70'h15_5555_5555_5555_5555) begin
      n_err++; $display("FAIL long_capture_chain: got %h expected 1555555555555555555", chain[69:0]);
    end
    e0 = en_cnt;
    run_cmd(ScanCmdRestore, 16'd70, '1, 0, 1'b0, lat);
    for (int i = 0; i < 70; i++) got[i] = sin_log[e0 + i];
    n_vec++;
    if (got !== {6'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_err++; $display("FAIL long_restore_stream: got %h expected 0ffffffffffffffff", got);
    end
  endtask

  task automatic test_ignored();
    int lat, e0, d0;
    load_chain(128'h96, 8);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 3'd3; shift_count = 16'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_vec++;
    if ({busy, freeze, state} !== {2'b00, ScanIdle}) begin
      n_err++; $display("FAIL reserved_cmd: got busy/freeze %b state %0d expected 00 / 0", {busy, freeze}, state);
    end
    e0 = en_cnt; d0 = done_cnt;
    run_cmd(ScanCmdCapture, 16'd8, '0, 5, 1'b1, lat);
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt - d0); end
    n_vec++;
    if (en_cnt - e0 !== 8) begin n_err++; $display("FAIL ignored_enables: got %0d expected 8", en_cnt - e0); end
    n_vec++;
    if (data_out !== 64'h96) begin n_err++; $display("FAIL ignored_data: got %h expected 96", data_out); end
  endtask

  task automatic test_reset_mid();
    int lat, d0, e0, guard;
    logic [7:0] snap;
    load_chain(128'hA5, 8);
    d0 = done_cnt; e0 = en_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = ScanCmdCapture; shift_count = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (en_cnt - e0 < 3 && guard < 40) begin @(negedge clk); guard++; end
    n_vec++;
    if (en_cnt - e0 !== 3) begin n_err++; $display("FAIL mid_reach_shift3: got %0d expected 3", en_cnt - e0); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, freeze, scan_en, scan_in} !== 5'b00000 || data_out !== 64'h0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %b data %h expected 00000 data 0",
                        {busy, done, freeze, scan_en, scan_in}, data_out);
    end
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL mid_reset_no_done: got %0d expected 0", done_cnt - d0); end
    snap = chain[7:0];
    n_vec++;
    if (snap !== 8'hB4) begin n_err++; $display("FAIL mid_reset_chain: got %h expected b4", snap); end
    run_cmd(ScanCmdCapture, 16'd8, '0, 0, 1'b0, lat);
    n_vec++;
    if (lat !== 10) begin n_err++; $display("FAIL post_reset_latency: got %0d expected 10", lat); end
    n_vec++;
    if (data_out !== 64'hB4) begin n_err++; $display("FAIL post_reset_data: got %h expected b4", data_out); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_capture();
    test_restore_capture();
    test_zero_count();
    test_long_chain();
    test_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/loom_scan_ctrl.md
# loom_scan_ctrl

Serial scan-chain controller for the emulation target: responds to scan commands from the host side (capture / restore), freezes the user design, and shifts a single-bit scan chain for a host-specified number of cycles. Capture reads chain state into a word while rotating the chain back onto itself (non-destructive). Restore writes a host word into the chain. Sits between the host interface (command side) and the scan-inserted design (chain side).

## Interface
Parameters:
- ScanDataWidth, 64, width of the capture/restore data word (W); must be ≥ 1.
- FreezeCycles, 1, settle cycles between freeze assertion and the first shift; range 1..15.

Ports:
- clk_i  in  1  design clock, single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  single-cycle command strobe.
- cmd_i  in  3  command code: 0 Nop, 1 Capture, 2 Restore; 3..7 reserved.
- shift_count_i  in  16  number of shift cycles N.
- data_i  in  W  restore data word.
- data_o  out  W  captured or echoed data word.
- busy_o  out  1  command in progress.
- done_o  out  1  single-cycle completion pulse.
- freeze_o  out  1  stalls user design state (clock-enable low).
- scan_enable_o  out  1  chain shift enable.
- scan_in_o  out  1  serial data into chain head.
- scan_out_i  in  1  serial data from chain tail.

## Operation
- States: Idle, Freeze, Shift, Done.
- Idle: command accepted when cmd_valid_i=1 and cmd_i ∈ {1,2}. Latch N and opcode; clear settle and shift counters; go to Freeze. Nop and reserved codes are ignored: no state change, no done.
- On Capture accept: data register cleared to 0. On Restore accept: data register loaded with data_i.
- Freeze: freeze_o=1. Stay FreezeCycles cycles, then go to Shift, or to Done if N=0.
- Shift: scan_enable_o=1 for exactly N cycles, with bit index k = 0..N-1.
  - Capture: if k<W, data[k] ← scan_out_i. scan_in_o = scan_out_i (loopback).
  - Restore: scan_in_o = data[k] if k<W, else 0. The data register is unchanged.
  - After shift N-1, go to Done.
- Done: done_o=1 for one cycle. data_o is valid. Return to Idle.
- data_o always reflects the data register and holds it until the next accepted command.
- Bit ordering: the first bit out of the chain is data[0], and the first bit shifted in is data[0]. A Restore followed by a Capture of the same N ≤ W therefore returns the restored word.
- N > W: Capture keeps the first W bits. Restore pads with zeros.

## Timing
- Reset values: data_o=0, busy_o=0, done_o=0, freeze_o=0, scan_enable_o=0, scan_in_o=0. State is Idle.
- Command strobe in cycle 0:
  - busy_o and freeze_o rise in cycle 1.
  - scan_enable_o is high in cycles 1+FreezeCycles .. FreezeCycles+N.
  - done_o is high in cycle 1+FreezeCycles+N. Latency = N+FreezeCycles+1 cycles.
- During the Done cycle: busy_o=0, freeze_o=1. freeze_o falls when the block returns to Idle.
- cmd_valid_i while busy or in Done is ignored, with no queuing. A command is accepted again from the cycle after done_o.
- All outputs are registered, except scan_in_o during Capture, which is a combinational loopback of scan_out_i.
- Shift counter is 16 bits. N=65535 completes without wrap.
- Reset asserted mid-operation: outputs return to reset values immediately (async). The chain is left partially shifted and no done is issued.

## Structure
- loom_scan_pkg holds the command code localparams (ScanCmdNop/Capture/Restore) and the state enum. The host-side command driver imports the same codes.
- No sub-modules; a single FSM plus counters.

## Test plan
- Capture: 8-bit looped chain model preloaded with 0xA5, N=8, FreezeCycles=1 -> done_o 10 cycles after the strobe, data_o=0x00…A5, chain still holds 0xA5.
- Restore then Capture: Restore data_i=0x3C, N=8, followed by Capture N=8 -> second done returns data_o=0x3C. Chain model holds 0x3C.
- N=0 Capture -> no scan_enable_o pulses, done_o 2 cycles after the strobe, data_o=0.
- N=70 > W=64 Capture on a chain of alternating 1/0 -> data_o=0x5555_5555_5555_5555, 70 enable cycles. N=70 Restore -> last 6 scan_in_o bits are 0.
- Second cmd_valid_i during Shift, and cmd_i=3 in Idle -> both ignored: exactly one done_o, counts unaffected.
- rst_ni low at shift 3 of 8 -> all outputs 0 asynchronously, no done_o. A new Capture after release completes normally.
